// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment scan controller: FSM encoding and
// abcdefg segment patterns (bit6 = a, 1 = lit).
package seg7_pkg;

    localparam int unsigned SEG_W = 7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHOW  = 2'd1,
        ST_BLANK = 2'd2
    } state_e;

    localparam logic [SEG_W-1:0] SEG_0     = 7'b1111110;
    localparam logic [SEG_W-1:0] SEG_1     = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_2     = 7'b1101101;
    localparam logic [SEG_W-1:0] SEG_3     = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_4     = 7'b0110011;
    localparam logic [SEG_W-1:0] SEG_5     = 7'b1011011;
    localparam logic [SEG_W-1:0] SEG_6     = 7'b1011111;
    localparam logic [SEG_W-1:0] SEG_7     = 7'b1110000;
    localparam logic [SEG_W-1:0] SEG_8     = 7'b1111111;
    localparam logic [SEG_W-1:0] SEG_9     = 7'b1111011;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational BCD to abcdefg decoder; codes 10-15 are rendered all-off.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0]       code_i,
    output logic [SEG_W-1:0] seg_c
);

    always_comb begin
        seg_c = SEG_BLANK;
        case (code_i)
            4'd0:    seg_c = SEG_0;
            4'd1:    seg_c = SEG_1;
            4'd2:    seg_c = SEG_2;
            4'd3:    seg_c = SEG_3;
            4'd4:    seg_c = SEG_4;
            4'd5:    seg_c = SEG_5;
            4'd6:    seg_c = SEG_6;
            4'd7:    seg_c = SEG_7;
            4'd8:    seg_c = SEG_8;
            4'd9:    seg_c = SEG_9;
            default: seg_c = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with double-buffered digits,
// per-position blanking guard, decimal points and leading-zero suppression.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int unsigned DIGITS       = 8,
    parameter int unsigned SHOW_CYCLES  = 50000,
    parameter int unsigned BLANK_CYCLES = 500,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [4*DIGITS-1:0]   digit_data,
    input  logic [DIGITS-1:0]     dp_mask,
    input  logic                  lz_suppress,
    input  logic                  load,
    output logic [2:0]            seg7_sel,
    output logic [SEG_W-1:0]      seg7_out,
    output logic                  dpt_out,
    output logic                  frame_done
);

    localparam int unsigned       IDX_W      = 3;
    localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(DIGITS - 1);
    localparam logic [CNT_W-1:0]  SHOW_LAST  = CNT_W'(SHOW_CYCLES - 1);
    localparam logic [CNT_W-1:0]  BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

    state_e                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [DIGITS-1:0][3:0]   shadow_dig_q, shadow_dig_d;
    logic [DIGITS-1:0]        shadow_dp_q, shadow_dp_d;
    logic                     load_pend_q, load_pend_d;

    logic [2:0]               seg7_sel_q, seg7_sel_d;
    logic [SEG_W-1:0]         seg7_out_q, seg7_out_d;
    logic                     dpt_out_q, dpt_out_d;
    logic                     frame_done_q, frame_done_d;

    logic                     frame_end;
    logic                     capture;
    logic [3:0]               cur_nib;
    logic                     cur_dp;
    logic                     lz_blank;
    logic [SEG_W-1:0]         dec_seg;

    // Next-state, double-buffer capture and lookup of the digit about to be shown.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        frame_end   = (state_q == ST_BLANK) && (cnt_q == BLANK_LAST) && (idx_q == IDX_LAST);

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (enable) state_d = ST_SHOW;
            end
            ST_SHOW: begin
                if (cnt_q == SHOW_LAST) begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = ST_SHOW;
                    cnt_d   = '0;
                    idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (!enable) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            idx_d   = '0;
        end

        // Shadow only changes between frames (or while idle) so a frame never tears.
        capture      = (load || load_pend_q) && ((state_q == ST_IDLE) || frame_end);
        shadow_dig_d = capture ? digit_data : shadow_dig_q;
        shadow_dp_d  = capture ? dp_mask    : shadow_dp_q;
        load_pend_d  = capture ? 1'b0 : (load_pend_q | load);

        cur_nib  = 4'd0;
        cur_dp   = 1'b0;
        lz_blank = lz_suppress && (idx_d != '0);
        for (int unsigned j = 0; j < DIGITS; j++) begin
            if (idx_d == IDX_W'(j)) begin
                cur_nib = shadow_dig_d[j];
                cur_dp  = shadow_dp_d[j];
            end
            if ((IDX_W'(j) >= idx_d) && (shadow_dig_d[j] != 4'd0)) lz_blank = 1'b0;
        end
    end

    seg7_hex_decode u_decode (
        .code_i (cur_nib),
        .seg_c  (dec_seg)
    );

    // Outputs are registered from the next state so they line up with it.
    always_comb begin
        seg7_sel_d   = idx_d;
        seg7_out_d   = ((state_d == ST_SHOW) && !lz_blank) ? dec_seg : SEG_BLANK;
        dpt_out_d    = (state_d == ST_SHOW) && cur_dp;
        frame_done_d = (state_d == ST_BLANK) && (idx_d == IDX_LAST) && (cnt_d == BLANK_LAST);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            shadow_dig_q <= '0;
            shadow_dp_q  <= '0;
            load_pend_q  <= 1'b0;
            seg7_sel_q   <= '0;
            seg7_out_q   <= SEG_BLANK;
            dpt_out_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shadow_dig_q <= shadow_dig_d;
            shadow_dp_q  <= shadow_dp_d;
            load_pend_q  <= load_pend_d;
            seg7_sel_q   <= seg7_sel_d;
            seg7_out_q   <= seg7_out_d;
            dpt_out_q    <= dpt_out_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg7_sel   = seg7_sel_q;
    assign seg7_out   = seg7_out_q;
    assign dpt_out    = dpt_out_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl (4 digits, 4 show + 2 blank cycles)
// using a frame-time reference model plus literal expectations.
module tb_seg7_scan_ctrl;

    localparam int DIGITS = 4;
    localparam int SHOW   = 4;
    localparam int SLOT   = 6;
    localparam int FRAME  = 24;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [15:0] digit_data;
    logic [3:0]  dp_mask;
    logic        lz_suppress;
    logic        load;
    logic [2:0]  seg7_sel;
    logic [6:0]  seg7_out;
    logic        dpt_out;
    logic        frame_done;

    always #5 clk = ~clk;

    seg7_scan_ctrl #(
        .DIGITS       (4),
        .SHOW_CYCLES  (4),
        .BLANK_CYCLES (2),
        .CNT_W        (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .digit_data  (digit_data),
        .dp_mask     (dp_mask),
        .lz_suppress (lz_suppress),
        .load        (load),
        .seg7_sel    (seg7_sel),
        .seg7_out    (seg7_out),
        .dpt_out     (dpt_out),
        .frame_done  (frame_done)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: position in the frame plus the displayed bank.
    bit          m_run;
    int          m_t;
    logic [15:0] m_dig;
    logic [3:0]  m_dp;
    bit          m_pend;
    logic [11:0] exp_vec;

    function automatic logic [6:0] ref_seg(input logic [3:0] n);
        case (n)
            4'd0: return 7'b1111110;
            4'd1: return 7'b0110000;
            4'd2: return 7'b1101101;
            4'd3: return 7'b1111001;
            4'd4: return 7'b0110011;
            4'd5: return 7'b1011011;
            4'd6: return 7'b1011111;
            4'd7: return 7'b1110000;
            4'd8: return 7'b1111111;
            4'd9: return 7'b1111011;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic logic [11:0] model_out();
        int          k;
        int          r;
        logic [6:0]  s;
        logic        d;
        logic [15:0] hi;
        if (!m_run) return 12'h000;
        k = m_t / SLOT;
        r = m_t % SLOT;
        s = 7'h00;
        d = 1'b0;
        if (r < SHOW) begin
            hi = m_dig >> (4 * k);
            s  = (lz_suppress && k > 0 && hi == 16'h0000) ? 7'h00 : ref_seg(hi[3:0]);
            d  = m_dp[k];
        end
        return {3'(k), s, d, (m_t == FRAME - 1)};
    endfunction

    function automatic logic [11:0] obs();
        return {seg7_sel, seg7_out, dpt_out, frame_done};
    endfunction

    task automatic model_edge();
        bit fe;
        bit cap;
        if (reset) begin
            m_run = 0; m_t = 0; m_dig = '0; m_dp = '0; m_pend = 0;
        end else begin
            fe  = m_run && (m_t == FRAME - 1);
            cap = (load || m_pend) && (!m_run || fe);
            if (cap) begin
                m_dig  = digit_data;
                m_dp   = dp_mask;
                m_pend = 0;
            end else if (load) begin
                m_pend = 1;
            end
            if (!enable)     begin m_run = 0; m_t = 0; end
            else if (!m_run) begin m_run = 1; m_t = 0; end
            else             m_t = (m_t + 1) % FRAME;
        end
        exp_vec = model_out();
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_load(input logic [15:0] d, input logic [3:0] m);
        enable = 1'b0;
        load   = 1'b0;
        tick();
        digit_data = d;
        dp_mask    = m;
        load       = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1; load = 1'b0;
        digit_data = 16'h0000; dp_mask = 4'h0; lz_suppress = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (obs() !== 12'h000) begin
                n_fail++;
                $display("FAIL reset cyc%0d: got %h want 000", i, obs());
            end
        end
        reset = 1'b0;
        tick();
        n_checks++;
        if (obs() !== {3'd0, 7'b1111110, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_release: got %h want %h", obs(), {3'd0, 7'b1111110, 2'b00});
        end
        n_checks++;
        if (obs() !== exp_vec) begin
            n_fail++;
            $display("FAIL reset_model: got %h want %h", obs(), exp_vec);
        end
    endtask

    task automatic test_basic_scan();
        logic [6:0]  lit [4] = '{7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011};
        logic [11:0] want;
        int          k, r, last_fd, fd_seen;
        idle_load(16'h4321, 4'b0010);
        lz_suppress = 1'b0;
        enable      = 1'b1;
        last_fd = -1;
        fd_seen = 0;
        for (int cyc = 0; cyc < 2 * FRAME; cyc++) begin
            tick();
            k    = (cyc % FRAME) / SLOT;
            r    = cyc % SLOT;
            want = {3'(k), (r < SHOW) ? lit[k] : 7'h00, (r < SHOW) && (k == 1), (cyc % FRAME) == FRAME - 1};
            n_checks++;
            if (obs() !== want) begin
                n_fail++;
                $display("FAIL basic_scan cyc%0d: got %h want %h", cyc, obs(), want);
            end
            n_checks++;
            if (obs() !== exp_vec) begin
                n_fail++;
                $display("FAIL basic_model cyc%0d: got %h want %h", cyc, obs(), exp_vec);
            end
            if (frame_done === 1'b1) begin
                fd_seen++;
                if (last_fd >= 0) begin
                    n_checks++;
                    if (cyc - last_fd !== FRAME) begin
                        n_fail++;
                        $display("FAIL frame_period: got %0d want %0d", cyc - last_fd, FRAME);
                    end
                end
                last_fd = cyc;
            end
        end
        n_checks++;
        if (fd_seen !== 2) begin
            n_fail++;
            $display("FAIL frame_done_count: got %0d want 2", fd_seen);
        end
    endtask

    task automatic test_leading_zeros();
        logic [6:0] lz_tab [4] = '{7'b1111110, 7'b1011011, 7'b0000000, 7'b0000000};
        int k, r;
        idle_load(16'h0050, 4'b0000);
        lz_suppress = 1'b1;
        enable      = 1'b1;
        for (int cyc = 0; cyc < 2 * FRAME; cyc++) begin
            if (cyc == FRAME) lz_suppress = 1'b0;
            tick();
            k = (cyc % FRAME) / SLOT;
            r = cyc % SLOT;
            n_checks++;
            if (obs() !== exp_vec) begin
                n_fail++;
                $display("FAIL lz_model cyc%0d: got %h want %h", cyc, obs(), exp_vec);
            end
            if (cyc < FRAME && r < SHOW) begin
                n_checks++;
                if (seg7_out !== lz_tab[k]) begin
                    n_fail++;
                    $display("FAIL lz_on digit%0d: got %b want %b", k, seg7_out, lz_tab[k]);
                end
            end
            if (cyc >= FRAME && k == 3 && r < SHOW) begin
                n_checks++;
                if (seg7_out !== 7'b1111110) begin
                    n_fail++;
                    $display("FAIL lz_off digit3: got %b want 1111110", seg7_out);
                end
            end
        end
    endtask

    task automatic test_tear_free();
        logic [6:0] want;
        bit         found;
        idle_load(16'h4321, 4'b0010);
        lz_suppress = 1'b0;
        enable      = 1'b1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (cyc == 6) begin load = 1'b1; digit_data = 16'h9999; end
            if (cyc == 7) load = 1'b0;
            tick();
            n_checks++;
            if (obs() !== exp_vec) begin
                n_fail++;
                $display("FAIL tear_model cyc%0d: got %h want %h", cyc, obs(), exp_vec);
            end
            want = 7'h7f;
            if (cyc >= 6  && cyc <= 9)  want = 7'b1101101;
            if (cyc >= 12 && cyc <= 15) want = 7'b1111001;
            if (cyc >= 18 && cyc <= 21) want = 7'b0110011;
            if (cyc >= 24 && cyc <= 27) want = 7'b1111011;
            if (want != 7'h7f) begin
                n_checks++;
                if (seg7_out !== want) begin
                    n_fail++;
                    $display("FAIL tear_data cyc%0d: got %b want %b", cyc, seg7_out, want);
                end
            end
        end
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (frame_done === 1'b1) found = 1;
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL tear_wait_frame_done: got timeout want pulse");
        end
        digit_data = 16'h8888;
        load       = 1'b1;
        tick();
        load = 1'b0;
        n_checks++;
        if ({seg7_sel, seg7_out} !== {3'd0, 7'b1111111}) begin
            n_fail++;
            $display("FAIL load_at_frame_done: got %h want %h", {seg7_sel, seg7_out}, {3'd0, 7'b1111111});
        end
        n_checks++;
        if (obs() !== exp_vec) begin
            n_fail++;
            $display("FAIL load_at_fd_model: got %h want %h", obs(), exp_vec);
        end
    endtask

    task automatic test_enable_drop();
        idle_load(16'h4321, 4'b0000);
        enable = 1'b1;
        for (int cyc = 0; cyc < 14; cyc++) begin
            if (cyc == 8) begin load = 1'b1; digit_data = 16'h1234; end
            if (cyc == 9) load = 1'b0;
            tick();
        end
        enable = 1'b0;
        tick();
        n_checks++;
        if (obs() !== 12'h000) begin
            n_fail++;
            $display("FAIL enable_drop: got %h want 000", obs());
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            n_checks++;
            if ({seg7_sel, frame_done} !== 4'h0) begin
                n_fail++;
                $display("FAIL idle_quiet cyc%0d: got %h want 0", i, {seg7_sel, frame_done});
            end
        end
        enable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (obs() !== ((i < 4) ? {3'd0, 7'b0110011, 2'b00} : 12'h000)) begin
                n_fail++;
                $display("FAIL reenable cyc%0d: got %h want %h", i, obs(),
                         (i < 4) ? {3'd0, 7'b0110011, 2'b00} : 12'h000);
            end
            n_checks++;
            if (obs() !== exp_vec) begin
                n_fail++;
                $display("FAIL reenable_model cyc%0d: got %h want %h", i, obs(), exp_vec);
            end
        end
    endtask

    task automatic test_invalid_code();
        idle_load(16'h0B00, 4'b0100);
        lz_suppress = 1'b0;
        enable      = 1'b1;
        for (int cyc = 0; cyc < FRAME; cyc++) begin
            tick();
            n_checks++;
            if (obs() !== exp_vec) begin
                n_fail++;
                $display("FAIL invalid_model cyc%0d: got %h want %h", cyc, obs(), exp_vec);
            end
            if (cyc >= 12 && cyc <= 15) begin
                n_checks++;
                if (obs() !== {3'd2, 7'b0000000, 1'b1, 1'b0}) begin
                    n_fail++;
                    $display("FAIL invalid_code cyc%0d: got %h want %h", cyc, obs(), {3'd2, 7'd0, 2'b10});
                end
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] masks [4] = '{16'h000F, 16'h00FF, 16'h0FFF, 16'hFFFF};
        for (int cyc = 0; cyc < 400; cyc++) begin
            reset  = ($urandom_range(0, 149) == 0);
            enable = ($urandom_range(0, 29) != 0);
            load   = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 3) == 0)
                digit_data = 16'($urandom) & masks[$urandom_range(0, 3)];
            if ($urandom_range(0, 3) == 0) dp_mask = 4'($urandom);
            if ($urandom_range(0, 15) == 0) lz_suppress = ~lz_suppress;
            tick();
            n_checks++;
            if (obs() !== exp_vec) begin
                n_fail++;
                $display("FAIL random cyc%0d: got %h want %h", cyc, obs(), exp_vec);
            end
        end
        reset = 1'b0;
        load  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        m_run = 0; m_t = 0; m_dig = '0; m_dp = '0; m_pend = 0; exp_vec = '0;
        test_reset();
        test_basic_scan();
        test_leading_zeros();
        test_tear_free();
        test_enable_drop();
        test_invalid_code();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
